// File: rtl/taylor_exp_core.sv
// taylor_exp_core: iterative fixed-point exp(x) by Taylor series in Horner form.
// One shared signed multiplier; start/busy/done handshake toward the register file.
module taylor_exp_core #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int NT_W   = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     start_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic        [NT_W-1:0]   n_terms_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic signed [DATA_W-1:0] result_o,
  output logic                     ovf_o
);

  localparam int NUM_K = 2**NT_W;
  localparam int PW    = 2*DATA_W;

  localparam logic signed [DATA_W-1:0] ONE  =
    {{(DATA_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Reciprocal table INV[k] = round(2^FRAC_W / k); entry 0 is never used.
  function automatic logic [NUM_K*DATA_W-1:0] build_inv();
    logic [NUM_K*DATA_W-1:0] t;
    t = '0;
    for (int unsigned k = 1; k < NUM_K; k++) begin
      t[k*DATA_W +: DATA_W] =
        DATA_W'(((64'd1 << FRAC_W) + 64'(k / 2)) / 64'(k));
    end
    return t;
  endfunction

  localparam logic [NUM_K*DATA_W-1:0] INV_TAB = build_inv();

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_X,
    S_MUL_INV,
    S_ACC,
    S_FIN
  } state_t;

  state_t r_state, w_next;

  logic signed [DATA_W-1:0] r_x;
  logic signed [DATA_W-1:0] r_acc;
  logic signed [DATA_W-1:0] r_p;
  logic signed [DATA_W-1:0] r_q;
  logic        [NT_W-1:0]   r_k;
  logic                     r_ovf;
  logic                     r_busy;
  logic                     r_done;
  logic signed [DATA_W-1:0] r_result;
  logic                     r_ovf_out;

  logic signed [DATA_W-1:0] w_inv;
  logic signed [DATA_W-1:0] w_mul_a;
  logic signed [DATA_W-1:0] w_mul_b;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-1:0]     w_shift;
  logic                     w_prod_ovf;
  logic signed [DATA_W-1:0] w_sat_prod;
  logic signed [DATA_W:0]   w_sum;
  logic                     w_sum_ovf;
  logic signed [DATA_W-1:0] w_sat_sum;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: three cycles per series term, then a single FIN cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next = (n_terms_i != '0) ? S_MUL_X : S_FIN;
        end
      end
      S_MUL_X:   w_next = S_MUL_INV;
      S_MUL_INV: w_next = S_ACC;
      S_ACC:     w_next = (r_k == NT_W'(1)) ? S_FIN : S_MUL_X;
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Shared multiplier operand select: x*acc in MUL_X, p*INV[k] in MUL_INV.
  always_comb begin
    w_inv   = INV_TAB[int'(r_k)*DATA_W +: DATA_W];
    w_mul_a = r_x;
    w_mul_b = r_acc;
    if (r_state == S_MUL_INV) begin
      w_mul_a = r_p;
      w_mul_b = w_inv;
    end
  end

  assign w_prod  = PW'(w_mul_a) * PW'(w_mul_b);
  assign w_shift = w_prod >>> FRAC_W;

  // Saturate the shifted product: it fits only if the top bits are a pure sign extension.
  always_comb begin
    w_prod_ovf = !((&w_shift[PW-1:DATA_W-1]) || (~|w_shift[PW-1:DATA_W-1]));
    w_sat_prod = w_shift[DATA_W-1:0];
    if (w_prod_ovf) begin
      w_sat_prod = w_shift[PW-1] ? SMIN : SMAX;
    end
  end

  assign w_sum = {ONE[DATA_W-1], ONE} + {r_q[DATA_W-1], r_q};

  // Saturate ONE+q using the extra sign bit of the widened sum.
  always_comb begin
    w_sum_ovf = w_sum[DATA_W] ^ w_sum[DATA_W-1];
    w_sat_sum = w_sum[DATA_W-1:0];
    if (w_sum_ovf) begin
      w_sat_sum = w_sum[DATA_W] ? SMIN : SMAX;
    end
  end

  // Datapath and handshake registers, advanced according to the current state.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_x       <= '0;
      r_acc     <= '0;
      r_p       <= '0;
      r_q       <= '0;
      r_k       <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_x    <= x_i;
            r_k    <= n_terms_i;
            r_acc  <= ONE;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        S_MUL_X: begin
          r_p <= w_sat_prod;
          if (w_prod_ovf) r_ovf <= 1'b1;
        end
        S_MUL_INV: begin
          r_q <= w_sat_prod;
          if (w_prod_ovf) r_ovf <= 1'b1;
        end
        S_ACC: begin
          r_acc <= w_sat_sum;
          r_k   <= r_k - NT_W'(1);
          if (w_sum_ovf) r_ovf <= 1'b1;
        end
        S_FIN: begin
          r_result  <= r_acc;
          r_ovf_out <= r_ovf;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;
  assign ovf_o    = r_ovf_out;

endmodule
